// File: rtl/fifo_memory_controller.sv
// First-word-fall-through FIFO controller that sequences an external dual-port memory
// with a registered read port, keeping a two-entry prefetch buffer for full throughput.
module fifo_memory_controller #(
   parameter int DATAWIDTH    = 8,
   parameter int DATADEPTH    = 8,
   parameter int ADDRESSWIDTH = $clog2(DATADEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [DATAWIDTH-1:0]    inData,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [DATAWIDTH-1:0]    outData,
   output logic                    memWriteEn,
   output logic [ADDRESSWIDTH-1:0] memWriteAddress,
   output logic [DATAWIDTH-1:0]    memDataIn,
   output logic [ADDRESSWIDTH-1:0] memReadAddress,
   input  logic [DATAWIDTH-1:0]    memDataOut,
   output logic [ADDRESSWIDTH:0]   level,
   output logic                    empty,
   output logic                    full
);

   localparam logic [ADDRESSWIDTH:0] DEPTH_C = (ADDRESSWIDTH+1)'(DATADEPTH);

   logic [ADDRESSWIDTH-1:0] write_ptr_q, write_ptr_d;
   logic [ADDRESSWIDTH-1:0] read_ptr_q, read_ptr_d;
   logic [ADDRESSWIDTH:0]   mem_count_q, mem_count_d;
   logic                    in_flight_q, in_flight_d;
   logic [1:0]              occ_q, occ_d;
   logic [DATAWIDTH-1:0]    head_q, head_d;
   logic [DATAWIDTH-1:0]    tail_q, tail_d;

   logic       push;
   logic       pop;
   logic       issue;
   logic [1:0] pending;
   logic [1:0] slot;

   always_comb begin
      inReady  = (mem_count_q != DEPTH_C);
      full     = !inReady;
      outValid = (occ_q != 2'd0);
      outData  = head_q;

      push = inValid & inReady & ~reset & ~flush;
      pop  = outValid & outReady;

      // Buffer entries still claimed after this cycle; never exceeds two.
      pending = occ_q + 2'(in_flight_q) - 2'(pop);
      issue   = (mem_count_q != '0) && (pending < 2'd2);
      slot    = occ_q - 2'(pop);

      memWriteEn      = push;
      memWriteAddress = write_ptr_q;
      memDataIn       = inData;
      memReadAddress  = read_ptr_q;

      level = mem_count_q + (ADDRESSWIDTH+1)'(in_flight_q) + (ADDRESSWIDTH+1)'(occ_q);
      empty = (level == '0);

      write_ptr_d = write_ptr_q + ADDRESSWIDTH'(push);
      read_ptr_d  = read_ptr_q + ADDRESSWIDTH'(issue);
      mem_count_d = mem_count_q + (ADDRESSWIDTH+1)'(push) - (ADDRESSWIDTH+1)'(issue);
      in_flight_d = issue;
      occ_d       = occ_q + 2'(in_flight_q) - 2'(pop);

      head_d = head_q;
      tail_d = tail_q;
      if (pop) begin
         head_d = tail_q;
      end
      if (in_flight_q) begin
         if (slot == 2'd0) begin
            head_d = memDataOut;
         end else begin
            tail_d = memDataOut;
         end
      end

      if (flush) begin
         write_ptr_d = '0;
         read_ptr_d  = '0;
         mem_count_d = '0;
         in_flight_d = 1'b0;
         occ_d       = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         write_ptr_q <= '0;
         read_ptr_q  <= '0;
         mem_count_q <= '0;
         in_flight_q <= 1'b0;
         occ_q       <= '0;
         // NOTE: the buffer data is reset so outData reads 0 after reset; the memory itself never is.
         head_q      <= '0;
         tail_q      <= '0;
      end else begin
         write_ptr_q <= write_ptr_d;
         read_ptr_q  <= read_ptr_d;
         mem_count_q <= mem_count_d;
         in_flight_q <= in_flight_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
      end
   end

endmodule
